// File: rtl/playfield_store_pkg.sv
// Shared types and constants for the playfield tile store and its readers.
// Pure declarations; no timing or flow-control behaviour of its own.
package playfield_store_pkg;

  localparam int PLAYFIELD_ROWS = 20;
  localparam int PLAYFIELD_COLS = 10;
  localparam int ROW_IDX_W      = 5;
  localparam int COL_IDX_W      = 4;

  typedef enum logic [3:0] {
    BLANK        = 4'd0,
    TILE_I       = 4'd1,
    TILE_O       = 4'd2,
    TILE_T       = 4'd3,
    TILE_S       = 4'd4,
    TILE_Z       = 4'd5,
    TILE_J       = 4'd6,
    TILE_L       = 4'd7,
    TILE_GARBAGE = 4'd8
  } tile_type_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    SCAN  = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } ps_state_t;

  function automatic bit rowIsFull(input tile_type_t row [PLAYFIELD_COLS]);
    bit full;
    full = 1'b1;
    for (int c = 0; c < PLAYFIELD_COLS; c++) begin
      if (row[c] == BLANK) full = 1'b0;
    end
    return full;
  endfunction

endpackage

// File: rtl/playfield_store_row_full.sv
// Flags a playfield row whose every cell is occupied.
// Purely combinational, zero latency; no flow control.
module row_full_detect
  import playfield_store_pkg::*;
#(
  parameter int COLS = PLAYFIELD_COLS
) (
  input  tile_type_t row [COLS],
  output logic       full
);

  logic [COLS-1:0] occ;

  always_comb begin
    occ = '0;
    for (int c = 0; c < COLS; c++) begin
      occ[c] = (row[c] != BLANK);
    end
  end

  assign full = &occ;

endmodule

// File: rtl/playfield_store.sv
// Authoritative tile grid: locks pieces, collapses full rows, serves a combinational read port.
// Lock takes 22 + rows-cleared cycles to done; lock_ready low (no accept) while busy.
module playfield_store
  import playfield_store_pkg::*;
#(
  parameter int ROWS = PLAYFIELD_ROWS,
  parameter int COLS = PLAYFIELD_COLS
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      lock_valid,
  output logic                      lock_ready,
  input  logic [3:0][ROW_IDX_W-1:0] lock_rows,
  input  logic [3:0][COL_IDX_W-1:0] lock_cols,
  input  tile_type_t                lock_type,
  input  logic                      clear_req,
  input  logic [ROW_IDX_W-1:0]      rd_row,
  input  logic [COL_IDX_W-1:0]      rd_col,
  output tile_type_t                rd_tile,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                lines_cleared,
  output logic                      lock_conflict
);

  ps_state_t                 state;
  tile_type_t                grid     [ROWS][COLS];
  tile_type_t                scan_row [COLS];
  logic [3:0][ROW_IDX_W-1:0] lk_rows;
  logic [3:0][COL_IDX_W-1:0] lk_cols;
  tile_type_t                lk_type;
  logic [ROW_IDX_W-1:0]      src;
  logic [ROW_IDX_W-1:0]      dst;
  logic [2:0]                cnt;
  logic [2:0]                cnt_inc;
  logic                      conflict;
  logic                      src_full;
  logic [3:0]                tile_ok;
  logic                      hit;

  always_comb begin
    for (int c = 0; c < COLS; c++) scan_row[c] = grid[src][c];
  end

  row_full_detect #(.COLS(COLS)) u_row_full (
    .row  (scan_row),
    .full (src_full)
  );

  // Occupancy is judged against the pre-write grid, so duplicate tiles never self-conflict.
  always_comb begin
    tile_ok = '0;
    hit     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tile_ok[i] = (int'(lk_rows[i]) < ROWS) && (int'(lk_cols[i]) < COLS);
      if (!tile_ok[i]) hit = 1'b1;
      else if (grid[lk_rows[i]][lk_cols[i]] != BLANK) hit = 1'b1;
    end
  end

  assign cnt_inc    = (cnt == 3'd7) ? cnt : cnt + 3'd1;
  assign lock_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);

  always_comb begin
    rd_tile = BLANK;
    if ((int'(rd_row) < ROWS) && (int'(rd_col) < COLS)) rd_tile = grid[rd_row][rd_col];
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state         <= IDLE;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) grid[r][c] <= BLANK;
      lk_rows       <= '0;
      lk_cols       <= '0;
      lk_type       <= BLANK;
      src           <= ROW_IDX_W'(ROWS - 1);
      dst           <= ROW_IDX_W'(ROWS - 1);
      cnt           <= '0;
      conflict      <= 1'b0;
      lines_cleared <= '0;
      lock_conflict <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++) grid[r][c] <= BLANK;
            cnt           <= '0;
            conflict      <= 1'b0;
            lines_cleared <= '0;
            lock_conflict <= 1'b0;
            state         <= DONE;
          end else if (lock_valid) begin
            lk_rows <= lock_rows;
            lk_cols <= lock_cols;
            lk_type <= lock_type;
            state   <= WRITE;
          end
        end
        WRITE: begin
          for (int i = 0; i < 4; i++) begin
            if (tile_ok[i]) grid[lk_rows[i]][lk_cols[i]] <= lk_type;
          end
          conflict <= hit;
          src      <= ROW_IDX_W'(ROWS - 1);
          dst      <= ROW_IDX_W'(ROWS - 1);
          cnt      <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          // Kept rows only move toward the bottom, into rows already scanned.
          if (src_full) begin
            cnt <= cnt_inc;
          end else begin
            if (src != dst) grid[dst] <= grid[src];
            if (dst != '0) dst <= dst - 1'b1;
          end
          if (src == '0) begin
            if (src_full || cnt != '0) begin
              state <= FILL;
            end else begin
              lines_cleared <= '0;
              lock_conflict <= conflict;
              state         <= DONE;
            end
          end else begin
            src <= src - 1'b1;
          end
        end
        FILL: begin
          for (int c = 0; c < COLS; c++) grid[dst][c] <= BLANK;
          if (dst == '0) begin
            lines_cleared <= cnt;
            lock_conflict <= conflict;
            state         <= DONE;
          end else begin
            dst <= dst - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_playfield_store.sv
// Randomized and directed bench for playfield_store against a row-list reference model.
`timescale 1ns/10ps
module tb_playfield_store;
  import playfield_store_pkg::*;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             lock_valid = 1'b0;
  logic             clear_req = 1'b0;
  logic             lock_ready, busy, done, lock_conflict;
  logic [3:0][4:0]  lock_rows = '0;
  logic [3:0][3:0]  lock_cols = '0;
  tile_type_t       lock_type = BLANK;
  tile_type_t       rd_tile;
  logic [4:0]       rd_row = '0;
  logic [3:0]       rd_col = '0;
  logic [2:0]       lines_cleared;

  int n_chk  = 0;
  int n_pass = 0;
  int m [20][10];

  always #5 clk = ~clk;

  playfield_store dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_rows     (lock_rows),
    .lock_cols     (lock_cols),
    .lock_type     (lock_type),
    .clear_req     (clear_req),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_tile       (rd_tile),
    .busy          (busy),
    .done          (done),
    .lines_cleared (lines_cleared),
    .lock_conflict (lock_conflict)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Caller must be in the clock low phase; each read settles in 20 ps.
  task automatic rd(input int r, input int c, output logic [31:0] v);
    rd_row = 5'(r);
    rd_col = 4'(c);
    #0.02;
    v = 32'(rd_tile);
  endtask

  task automatic rd_chk(input string tag, input int r, input int c, input int exp);
    logic [31:0] v;
    @(negedge clk);
    rd(r, c, v);
    chk(tag, v, exp);
  endtask

  task automatic check_field(input string tag);
    logic [31:0] v;
    int bad;
    bad = 0;
    @(negedge clk);
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) begin
        rd(r, c, v);
        if (v !== 32'(m[r][c])) bad++;
      end
    chk(tag, bad, 0);
  endtask

  task automatic model_blank();
    for (int r = 0; r < 20; r++)
      for (int c = 0; c < 10; c++) m[r][c] = 0;
  endtask

  // Field after a lock = blank rows on top of the surviving rows, in their original order.
  task automatic model_lock(input logic [3:0][4:0] r, input logic [3:0][3:0] c, input int t,
                            output int conf, output int lines);
    int old [20][10];
    int keep [$];
    int filled;
    conf = 0;
    for (int i = 0; i < 4; i++) begin
      if (r[i] >= 20 || c[i] >= 10) conf = 1;
      else if (m[r[i]][c[i]] != 0 && m[r[i]][c[i]] != t) conf = 1;
      else if (m[r[i]][c[i]] != 0) begin
        // occupied before this lock only if no earlier tile of this lock wrote it
        filled = 0;
        for (int j = 0; j < i; j++) if (r[j] == r[i] && c[j] == c[i]) filled = 1;
        if (!filled) conf = 1;
      end
      if (r[i] < 20 && c[i] < 10) m[r[i]][c[i]] = t;
    end
    old = m;
    for (int row = 0; row < 20; row++) begin
      filled = 0;
      for (int cc = 0; cc < 10; cc++) if (old[row][cc] != 0) filled++;
      if (filled < 10) keep.push_back(row);
    end
    lines = 20 - keep.size();
    for (int row = 0; row < 20; row++) begin
      if (row < lines) for (int cc = 0; cc < 10; cc++) m[row][cc] = 0;
      else m[row] = old[keep[row - lines]];
    end
  endtask

  task automatic do_lock(input logic [3:0][4:0] r, input logic [3:0][3:0] c,
                         input tile_type_t t, input string tag);
    int conf, lines, n;
    @(negedge clk);
    chk({tag, "_ready"}, lock_ready, 1);
    lock_rows  = r;
    lock_cols  = c;
    lock_type  = t;
    lock_valid = 1'b1;
    @(posedge clk);
    #1 lock_valid = 1'b0;
    model_lock(r, c, int'(t), conf, lines);
    n = 1;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 22 + lines);
    chk({tag, "_lines"}, lines_cleared, lines);
    chk({tag, "_conf"}, lock_conflict, conf);
    @(posedge clk);
    #1 chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic lock4(input int r0, input int c0, input int r1, input int c1,
                       input int r2, input int c2, input int r3, input int c3,
                       input tile_type_t t, input string tag);
    logic [3:0][4:0] r;
    logic [3:0][3:0] c;
    r[0] = 5'(r0); c[0] = 4'(c0);
    r[1] = 5'(r1); c[1] = 4'(c1);
    r[2] = 5'(r2); c[2] = 4'(c2);
    r[3] = 5'(r3); c[3] = 4'(c3);
    do_lock(r, c, t, tag);
  endtask

  task automatic fill_row(input int row, input int lo, input int hi, input tile_type_t t);
    for (int c = lo; c <= hi; c += 4)
      lock4(row, c, row, (c + 1 > hi) ? hi : c + 1, row, (c + 2 > hi) ? hi : c + 2,
            row, (c + 3 > hi) ? hi : c + 3, t, "fill");
  endtask

  task automatic do_clear(input bit with_lock, input string tag);
    @(negedge clk);
    clear_req  = 1'b1;
    lock_valid = with_lock;
    for (int i = 0; i < 4; i++) begin
      lock_rows[i] = 5'd0;
      lock_cols[i] = 4'(i);
    end
    lock_type = TILE_Z;
    @(posedge clk);
    #1;
    clear_req  = 1'b0;
    lock_valid = 1'b0;
    model_blank();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_lines"}, lines_cleared, 0);
    chk({tag, "_conf"}, lock_conflict, 0);
    @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    check_field({tag, "_field"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0][4:0] rr;
    logic [3:0][3:0] cc;
    tile_type_t      tt;

    model_blank();
    check_field("reset_field");
    chk("reset_busy", busy, 0);
    chk("reset_ready", lock_ready, 1);
    chk("reset_done", done, 0);
    chk("reset_lines", lines_cleared, 0);
    chk("reset_conf", lock_conflict, 0);
    @(negedge clk);
    rst_l = 1'b1;
    rd_chk("oor_row", 20, 0, 0);
    rd_chk("oor_col", 0, 10, 0);
    rd_chk("oor_both", 31, 15, 0);

    lock4(18, 4, 18, 5, 19, 4, 19, 5, TILE_O, "o_lock");
    rd_chk("o_cell", 18, 5, int'(TILE_O));
    check_field("o_field");

    lock4(19, 4, 17, 4, 17, 5, 20, 4, TILE_T, "conf_lock");
    chk("conf_flag", lock_conflict, 1);
    rd_chk("conf_overwrite", 19, 4, int'(TILE_T));
    check_field("conf_field");

    do_clear(1'b1, "clr_lock");

    for (int r = 16; r < 20; r++) fill_row(r, 0, 8, TILE_GARBAGE);
    lock4(12, 5, 12, 5, 12, 5, 12, 5, TILE_T, "t_pre");
    lock4(16, 9, 17, 9, 18, 9, 19, 9, TILE_I, "i_lock");
    chk("i_lines4", lines_cleared, 4);
    rd_chk("i_t_moved", 16, 5, int'(TILE_T));
    check_field("i_field");

    do_clear(1'b0, "clr");

    fill_row(19, 0, 8, TILE_GARBAGE);
    fill_row(17, 0, 8, TILE_GARBAGE);
    lock4(18, 0, 18, 0, 18, 0, 18, 0, TILE_J, "j_pre");
    lock4(17, 9, 19, 9, 17, 9, 19, 9, TILE_L, "nadj");
    chk("nadj_lines2", lines_cleared, 2);
    rd_chk("nadj_j", 19, 0, int'(TILE_J));
    check_field("nadj_field");

    @(negedge clk);
    lock_rows  = '0;
    lock_cols  = '0;
    lock_type  = TILE_S;
    lock_valid = 1'b1;
    @(posedge clk);
    #1 lock_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst_l = 1'b0;
    #1;
    model_blank();
    chk("rst_busy", busy, 0);
    chk("rst_ready", lock_ready, 1);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_done", done, 0);
    check_field("rst_field");
    @(negedge clk);
    rst_l = 1'b1;

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        do_clear(1'($urandom_range(0, 1)), "rnd_clr");
      end else begin
        for (int i = 0; i < 4; i++) begin
          rr[i] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(14, 19));
          cc[i] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        end
        tt = tile_type_t'($urandom_range(1, 8));
        do_lock(rr, cc, tt, "rnd");
        if (k % 8 == 7) check_field("rnd_field");
      end
    end
    check_field("rnd_final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
